// File: rtl/dff_pipe_pkg.sv
// Shared types and helpers for the dff_pipe programmable delay line.
package dff_pipe_pkg;

  // Per-edge action applied to the whole pipeline.
  typedef enum logic [1:0] {
    PIPE_HOLD = 2'd0,
    PIPE_ADV  = 2'd1,
    PIPE_CLR  = 2'd2
  } pipe_op_e;

  // Ceiling log2 that never returns less than 1, so a select or count
  // port always has at least one bit even for a single-stage pipe.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) begin
        r = 32'(i) + 32'd1;
      end else begin
        r = r;
      end
    end
    if (r < 32'd1) begin
      return 32'd1;
    end else begin
      return r;
    end
  endfunction

endpackage

// File: rtl/dff_pipe_dff.sv
// Single D flip-flop stage with synchronous active-high reset.
// The caller supplies the hold/advance mux ahead of i_d.
module dff_pipe_dff #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] q_r;

  // Capture the next stage value, clearing on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_r <= '0;
    end else begin
      q_r <= i_d;
    end
  end

  assign o_q = q_r;

endmodule

// File: rtl/dff_pipe.sv
// Clock-enabled register pipeline with per-stage valid bits, synchronous
// flush, a run-time output tap (clamped to the last stage) and a
// registered fill count of valid stages.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAP_W = clog2_min1(DEPTH),
  parameter int unsigned CNT_W = clog2_min1(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_d,
  input  logic [TAP_W-1:0] i_tap,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_fill
);

  // Each stage stores {valid, data}; bit WIDTH is the valid flag.
  logic [WIDTH:0] stage_q_s [DEPTH];
  logic [WIDTH:0] stage_d_s [DEPTH];
  logic           stage_clr_s;
  pipe_op_e       op_s;
  logic [CNT_W-1:0] fill_nxt_s;
  logic [CNT_W-1:0] fill_r;
  logic [WIDTH:0]   tap_sel_s;

  // Decode the per-edge action: reset and flush both clear, then enable.
  always_comb begin
    if (i_rst || i_flush) begin
      op_s = PIPE_CLR;
    end else if (i_en) begin
      op_s = PIPE_ADV;
    end else begin
      op_s = PIPE_HOLD;
    end
  end

  // Flush shares the stage reset so a flushed input is never captured.
  assign stage_clr_s = i_rst | i_flush;

  for (genvar n = 0; n < DEPTH; n++) begin : g_stage
    logic [WIDTH:0] src_s;

    if (n == 0) begin : g_head
      assign src_s = {i_valid, i_d};
    end else begin : g_body
      assign src_s = stage_q_s[n-1];
    end

    // Advance from the upstream source when enabled, otherwise hold.
    always_comb begin
      case (op_s)
        PIPE_ADV: stage_d_s[n] = src_s;
        default:  stage_d_s[n] = stage_q_s[n];
      endcase
    end

    dff_pipe_dff #(
      .W (WIDTH + 1)
    ) u_stage (
      .i_clk (i_clk),
      .i_rst (stage_clr_s),
      .i_d   (stage_d_s[n]),
      .o_q   (stage_q_s[n])
    );
  end

  // Popcount of the valid bits the stages will hold after this edge.
  always_comb begin
    fill_nxt_s = {CNT_W{1'b0}};
    for (int i = 0; i < int'(DEPTH); i++) begin
      fill_nxt_s = fill_nxt_s + CNT_W'(stage_d_s[i][WIDTH]);
    end
  end

  // Fill count register, updated on the same edge as the valid bits.
  always_ff @(posedge i_clk) begin
    if (op_s == PIPE_CLR) begin
      fill_r <= {CNT_W{1'b0}};
    end else begin
      fill_r <= fill_nxt_s;
    end
  end

  // Tap mux; any select past the last stage resolves to the last stage.
  always_comb begin
    tap_sel_s = stage_q_s[DEPTH-1];
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (32'(i_tap) == 32'(i)) begin
        tap_sel_s = stage_q_s[i];
      end else begin
        tap_sel_s = tap_sel_s;
      end
    end
  end

  assign o_q     = tap_sel_s[WIDTH-1:0];
  assign o_valid = tap_sel_s[WIDTH];
  assign o_fill  = fill_r;

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised register pipeline for the iCESDM datapath: a chain of `DEPTH` clock-enabled `WIDTH`-bit stages with per-stage valid tracking, synchronous flush and a run-time selectable output tap. It generalises the single D flip-flop into a programmable delay line. It sits between the modulator bitstream/decimator outputs and downstream consumers, aligning channels whose paths differ in latency.

## Interface
- `WIDTH`, 1, data width of each stage.
- `DEPTH`, 4, number of stages (≥1); the maximum delay in enabled cycles.
- `TAP_W`, `$clog2(DEPTH)` (min 1), width of the tap select.
- `CNT_W`, `$clog2(DEPTH+1)`, width of the fill count.

Ports:
- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_en`  in  1  clock enable; the pipeline advances only when high.
- `i_flush`  in  1  synchronous clear of all stages and valid bits.
- `i_valid`  in  1  qualifies `i_d`.
- `i_d`  in  `WIDTH`  input sample.
- `i_tap`  in  `TAP_W`  output tap select; a value of k gives a delay of k+1 enabled cycles.
- `o_q`  out  `WIDTH`  data at the selected stage.
- `o_valid`  out  1  valid bit at the selected stage.
- `o_fill`  out  `CNT_W`  number of stages currently holding valid data.

## Operation
- State consists of `stage[0..DEPTH-1]` (each `WIDTH` bits) and `vld[0..DEPTH-1]`.
- Priority per edge, highest first: `i_rst` > `i_flush` > `i_en` > hold.
- **Reset** (`i_rst`=1): all stages and valid bits go to 0. The power-up initial value is also all-zero.
- **Flush** (`i_flush`=1, `i_rst`=0): all stages and valid bits clear to 0. The input presented in the same cycle is discarded, even if `i_en` and `i_valid` are high.
- **Advance** (`i_en`=1, no reset or flush):
  - `stage[0]` ← `i_d` and `vld[0]` ← `i_valid`.
  - `stage[n]` ← `stage[n-1]` and `vld[n]` ← `vld[n-1]` for n ≥ 1.
  - The last stage is overwritten; there is no backpressure.
- **Hold** (`i_en`=0): no state changes. `i_d` and `i_valid` are ignored.
- **Data on invalid samples**: `stage` loads `i_d` regardless of `i_valid`. Downstream logic must qualify the data with `o_valid`.
- **Tap select**: `o_q` = `stage[t]` and `o_valid` = `vld[t]`, where t = min(`i_tap`, DEPTH-1). An out-of-range tap clamps to the last stage.
- **Fill count**: `o_fill` = popcount of `vld`, ranging 0..DEPTH. It is a registered popcount, updated in the same edge as `vld`.

## Timing
- **Outputs**:
  - `o_q` and `o_valid` are a combinational mux of registered state plus `i_tap`, so a change on `i_tap` takes effect in the same cycle.
  - `o_fill` is registered.
  - All outputs are 0 after reset.
- **Latency**: a sample accepted on edge E (with `i_en`=1) is visible at tap k after k+1 enabled edges counted from E inclusive. With `i_en` held high and k=0, it appears in the cycle after E.
- **Enable gaps**: cycles with `i_en`=0 do not count toward the delay. Data dwell time scales with the enable duty cycle.
- **Tap change mid-stream**: no state is disturbed. The output immediately reflects the newly selected stage, which can repeat or skip samples; this is intended.
- **Reset or flush mid-operation**: takes effect on that edge. `o_fill` reads 0 and `o_valid` reads 0 in the following cycle.
- **DEPTH=1**: `i_tap` is ignored and the block behaves as a single enabled register with a valid bit.

## Structure
- Shared header `sdm_defs.vh` carries the `CLOG2` helper macro used for `TAP_W` and `CNT_W`. No other shared constants are needed.
- Natural sub-module: the existing `dff` instantiated per stage (width `WIDTH+1` for data plus valid).
  - The enable/hold mux sits ahead of each `d` input.
  - Flush is folded into each stage's reset input (`i_rst | i_flush`).
- The popcount register and the tap mux live in the top level.

## Test plan
- **Reset**: after `i_rst` for 2 cycles, `o_q`=0, `o_valid`=0, `o_fill`=0 regardless of `i_tap`.
- **Full delay**: WIDTH=8, DEPTH=4, `i_tap`=3, `i_en`=1, stream 0x11,0x22,0x33,0x44,0x55 → 0x11 appears at `o_q` with `o_valid`=1 exactly 4 cycles after acceptance, and `o_fill` reaches 4.
- **Enable gap**: same stream with `i_en` low every other cycle and `i_tap`=1 → each sample appears after 2 enabled edges, and held values are unchanged while `i_en`=0.
- **Flush vs. enable**: with a full pipe, assert `i_flush`, `i_en` and `i_valid` with `i_d`=0xAA → the next cycle shows `o_fill`=0 and `o_valid`=0, and 0xAA never appears at any tap.
- **Tap clamp and live switch**: DEPTH=3, `i_tap`=3 → behaves as tap 2. Switching `i_tap` from 2 to 0 mid-stream shows the newest sample in the same cycle.
- **Invalid samples**: alternate `i_valid` 1/0 over 4 samples → `o_fill` settles at 2 for DEPTH=4, and `o_valid` toggles at the tap.
